// File: rtl/green_i2c_master.sv
`default_nettype none
// ==== green_i2c_master : one-byte-per-command I2C master (START/STOP, clock stretching, ====
// ==== arbitration-loss detection, open-drain pad enables)                  rev 1.0     ====
module green_i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       Clk_100,
  input  logic       SoftReset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_arb_lost,
  input  logic       b2g_I2C0_scl,
  input  logic       b2g_I2C0_sda,
  output logic       g2b_I2C0_scl,
  output logic       g2b_I2C0_sda,
  output logic       oen_I2C0_scl,
  output logic       oen_I2C0_sda
);

  // Once SCL is seen high after a stretch, finish the quarter so that the
  // total delay equals the stretch length despite the 2-cycle synchronizer.
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);
  localparam logic [11:0] Q1_LAST  = 12'((CLK_DIV > 3) ? (CLK_DIV - 3) : 0);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, RESP} state_t;

  state_t      state;
  logic [1:0]  scl_sync;
  logic [1:0]  sda_sync;
  logic [11:0] timer;
  logic        waiting;
  logic [1:0]  quarter;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        stop_r;
  logic        read_r;
  logic        nack_r;

  logic scl_s;
  logic sda_s;
  logic at_end;
  logic scl_wait_q;
  logic q_done;
  logic enter_wait;

  assign scl_s        = scl_sync[1];
  assign sda_s        = sda_sync[1];
  assign g2b_I2C0_scl = 1'b0;
  assign g2b_I2C0_sda = 1'b0;

  always_comb begin
    at_end     = (timer == DIV_LAST);
    scl_wait_q = (quarter == 2'd1) &&
                 (state == START || state == BIT || state == ACK || state == STOP);
    q_done     = 1'b0;
    enter_wait = 1'b0;
    if (state != IDLE && state != RESP) begin
      if (scl_wait_q && waiting) begin
        q_done = scl_s && (timer == Q1_LAST);
      end else if (scl_wait_q) begin
        q_done     = at_end && scl_s;
        enter_wait = at_end && !scl_s;
      end else begin
        q_done = at_end;
      end
    end
  end

  always_ff @(posedge Clk_100) begin
    if (SoftReset) begin
      state        <= IDLE;
      scl_sync     <= 2'b11;
      sda_sync     <= 2'b11;
      timer        <= 12'd0;
      waiting      <= 1'b0;
      quarter      <= 2'd0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      stop_r       <= 1'b0;
      read_r       <= 1'b0;
      nack_r       <= 1'b0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'd0;
      rsp_nack     <= 1'b0;
      rsp_arb_lost <= 1'b0;
      oen_I2C0_scl <= 1'b0;
      oen_I2C0_sda <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], b2g_I2C0_scl};
      sda_sync  <= {sda_sync[0], b2g_I2C0_sda};
      rsp_valid <= 1'b0;

      if (state == IDLE || state == RESP || q_done) begin
        timer   <= 12'd0;
        waiting <= 1'b0;
      end else if (enter_wait) begin
        timer   <= 12'd0;
        waiting <= 1'b1;
      end else if (waiting && !scl_s) begin
        timer <= 12'd0;
      end else begin
        timer <= timer + 12'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            stop_r       <= cmd_stop;
            read_r       <= cmd_read;
            nack_r       <= cmd_nack;
            shreg        <= cmd_wdata;
            rsp_rdata    <= 8'd0;
            rsp_nack     <= 1'b0;
            rsp_arb_lost <= 1'b0;
            quarter      <= 2'd0;
            bit_cnt      <= 3'd0;
            if (cmd_start) begin
              state        <= START;
              oen_I2C0_sda <= 1'b0;
            end else begin
              state        <= BIT;
              oen_I2C0_scl <= 1'b1;
              oen_I2C0_sda <= !cmd_read && !cmd_wdata[7];
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        START: begin
          if (q_done) begin
            case (quarter)
              2'd0: begin quarter <= 2'd1; oen_I2C0_scl <= 1'b0; end
              2'd1: begin quarter <= 2'd2; oen_I2C0_sda <= 1'b1; end
              2'd2: begin quarter <= 2'd3; oen_I2C0_scl <= 1'b1; end
              2'd3: begin
                state        <= BIT;
                quarter      <= 2'd0;
                oen_I2C0_sda <= !read_r && !shreg[7];
              end
            endcase
          end
        end

        BIT: begin
          if (q_done) begin
            case (quarter)
              2'd0: begin quarter <= 2'd1; oen_I2C0_scl <= 1'b0; end
              2'd1: quarter <= 2'd2;
              2'd2: begin
                // Released a 1 but the bus reads 0: another master owns the bus.
                if (!read_r && !oen_I2C0_sda && !sda_s) begin
                  state        <= RESP;
                  rsp_arb_lost <= 1'b1;
                  oen_I2C0_scl <= 1'b0;
                  oen_I2C0_sda <= 1'b0;
                end else begin
                  shreg        <= {shreg[6:0], sda_s};
                  quarter      <= 2'd3;
                  oen_I2C0_scl <= 1'b1;
                end
              end
              2'd3: begin
                quarter <= 2'd0;
                if (bit_cnt == 3'd7) begin
                  state        <= ACK;
                  rsp_rdata    <= read_r ? shreg : 8'd0;
                  oen_I2C0_sda <= read_r && !nack_r;
                end else begin
                  bit_cnt      <= bit_cnt + 3'd1;
                  oen_I2C0_sda <= !read_r && !shreg[7];
                end
              end
            endcase
          end
        end

        ACK: begin
          if (q_done) begin
            case (quarter)
              2'd0: begin quarter <= 2'd1; oen_I2C0_scl <= 1'b0; end
              2'd1: quarter <= 2'd2;
              2'd2: begin
                if (!read_r) rsp_nack <= sda_s;
                quarter      <= 2'd3;
                oen_I2C0_scl <= 1'b1;
              end
              2'd3: begin
                quarter <= 2'd0;
                if (stop_r) begin
                  state        <= STOP;
                  oen_I2C0_sda <= 1'b1;
                end else begin
                  state        <= RESP;
                  oen_I2C0_sda <= 1'b0;
                end
              end
            endcase
          end
        end

        STOP: begin
          if (q_done) begin
            case (quarter)
              2'd0:    begin quarter <= 2'd1; oen_I2C0_scl <= 1'b0; end
              2'd1:    begin quarter <= 2'd2; oen_I2C0_sda <= 1'b0; end
              default: begin quarter <= 2'd0; state <= RESP; end
            endcase
          end
        end

        RESP: begin
          rsp_valid <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_green_i2c_master.sv
`default_nettype none
// Directed bench for green_i2c_master at CLK_DIV=4 with a behavioural open-drain bus and slave.
module tb_green_i2c_master;

  localparam int NONE = -1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       cmd_read = 1'b0;
  logic       cmd_nack = 1'b0;
  logic [7:0] cmd_wdata = 8'd0;
  wire        cmd_ready;
  wire        rsp_valid;
  wire  [7:0] rsp_rdata;
  wire        rsp_nack;
  wire        rsp_arb_lost;
  wire        g2b_scl;
  wire        g2b_sda;
  wire        oen_scl;
  wire        oen_sda;

  logic stretch_low = 1'b0;
  logic slave_low   = 1'b0;
  logic other_low   = 1'b0;
  wire  scl_line;
  wire  sda_line;
  assign scl_line = ~(oen_scl | stretch_low);
  assign sda_line = ~(oen_sda | slave_low | other_low);

  green_i2c_master #(.CLK_DIV(4)) dut (
    .Clk_100      (clk),
    .SoftReset    (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_read     (cmd_read),
    .cmd_wdata    (cmd_wdata),
    .cmd_nack     (cmd_nack),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_nack     (rsp_nack),
    .rsp_arb_lost (rsp_arb_lost),
    .b2g_I2C0_scl (scl_line),
    .b2g_I2C0_sda (sda_line),
    .g2b_I2C0_scl (g2b_scl),
    .g2b_I2C0_sda (g2b_sda),
    .oen_I2C0_scl (oen_scl),
    .oen_I2C0_sda (oen_sda)
  );

  int checks = 0;
  int passed = 0;

  // Slave: 0 passive, 1 ACKs a write, 2 returns rbyte. Fall k (1..8) precedes data bit k-1.
  int         slave_mode = 0;
  logic       arb_mode = 1'b0;
  logic [7:0] rbyte = 8'd0;
  int         fall_cnt = 0;
  int         rise_cnt = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic       rise_bits [0:15];

  always @(negedge scl_line) begin
    fall_cnt++;
    if (slave_mode == 1) slave_low = (fall_cnt == 9);
    else if (slave_mode == 2) slave_low = (fall_cnt >= 1 && fall_cnt <= 8) ? ~rbyte[8 - fall_cnt] : 1'b0;
    if (arb_mode && fall_cnt == 3) other_low = 1'b1;
  end

  always @(posedge scl_line) begin
    rise_cnt++;
    if (rise_cnt < 16) rise_bits[rise_cnt] = sda_line;
  end

  always @(negedge sda_line) if (scl_line === 1'b1) start_cnt++;
  always @(posedge sda_line) if (scl_line === 1'b1) stop_cnt++;

  logic       tr_scl [0:511];
  logic       tr_sda [0:511];
  logic       tr_rdy [0:511];
  logic       g_seen;
  int         g_lat;
  int         g_tmr;
  logic [7:0] cap_rdata;
  logic       cap_nack;
  logic       cap_arb;

  // Offers one command, then records edges n=1..budget after the accepting edge.
  task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic [7:0] wd,
                         input logic nk, input int budget, input int stretch_at, input int rst_at);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    fall_cnt  = 0;
    rise_cnt  = 0;
    cmd_start = st;
    cmd_stop  = sp;
    cmd_read  = rd;
    cmd_wdata = wd;
    cmd_nack  = nk;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    g_seen = 1'b0;
    g_lat  = 0;
    g_tmr  = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      tr_scl[n] = oen_scl;
      tr_sda[n] = oen_sda;
      tr_rdy[n] = cmd_ready;
      if (n == stretch_at + 30) g_tmr = int'(dut.timer);
      if (rsp_valid === 1'b1 && !g_seen) begin
        g_seen    = 1'b1;
        g_lat     = n;
        cap_rdata = rsp_rdata;
        cap_nack  = rsp_nack;
        cap_arb   = rsp_arb_lost;
      end
      if (n == stretch_at - 1) stretch_low = 1'b1;
      if (n == stretch_at + 50) stretch_low = 1'b0;
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) rst = 1'b0;
      if (g_seen && rst_at == NONE) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); else passed++;
    checks++; if ({oen_scl, oen_sda} !== 2'b00) $display("FAIL reset_oen got=%b want=00", {oen_scl, oen_sda}); else passed++;
    checks++; if ({rsp_rdata, rsp_nack, rsp_arb_lost} !== 10'd0) $display("FAIL reset_rsp got=%h want=000", {rsp_rdata, rsp_nack, rsp_arb_lost}); else passed++;
    checks++; if ({g2b_scl, g2b_sda} !== 2'b00) $display("FAIL pad_data got=%b want=00", {g2b_scl, g2b_sda}); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset got=%b want=1", cmd_ready); else passed++;
  endtask

  task automatic test_write_start_stop();
    int st0, sp0;
    logic [7:0] pat;
    slave_mode = 1;
    st0 = start_cnt;
    sp0 = stop_cnt;
    run_cmd(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 400, NONE, NONE);
    for (int i = 1; i <= 8; i++) pat[8 - i] = rise_bits[i];
    checks++; if (g_seen !== 1'b1) $display("FAIL wr_rsp_seen got=%b want=1", g_seen); else passed++;
    checks++; if (g_lat != 173) $display("FAIL wr_latency got=%0d want=173", g_lat); else passed++;
    checks++; if (pat !== 8'hA5) $display("FAIL wr_sda_pattern got=%h want=a5", pat); else passed++;
    checks++; if ({cap_nack, cap_arb, cap_rdata} !== 10'd0) $display("FAIL wr_rsp_fields got=%h want=000", {cap_nack, cap_arb, cap_rdata}); else passed++;
    checks++; if (start_cnt - st0 != 1 || stop_cnt - sp0 != 1) $display("FAIL wr_start_stop got=%0d/%0d want=1/1", start_cnt - st0, stop_cnt - sp0); else passed++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse_width got=%b want=0", rsp_valid); else passed++;
    slave_mode = 0;
  endtask

  task automatic test_read_nack();
    int bad;
    slave_mode = 2;
    rbyte = 8'h3C;
    run_cmd(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 400, NONE, NONE);
    bad = 0;
    for (int n = 128; n <= 143; n++) if (tr_sda[n] !== 1'b0) bad++;
    checks++; if (g_lat != 157) $display("FAIL rd_latency got=%0d want=157", g_lat); else passed++;
    checks++; if (cap_rdata !== 8'h3C) $display("FAIL rd_data got=%h want=3c", cap_rdata); else passed++;
    checks++; if (bad != 0) $display("FAIL rd_ack_sda_released got=%0d_driven_cycles want=0", bad); else passed++;
    slave_mode = 0;
  endtask

  task automatic test_write_noack();
    int sp0;
    slave_mode = 0;
    sp0 = stop_cnt;
    run_cmd(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 400, NONE, NONE);
    checks++; if (g_lat != 173) $display("FAIL noack_latency got=%0d want=173", g_lat); else passed++;
    checks++; if (cap_nack !== 1'b1) $display("FAIL noack_rsp_nack got=%b want=1", cap_nack); else passed++;
    checks++; if (stop_cnt - sp0 != 1) $display("FAIL noack_stop got=%0d want=1", stop_cnt - sp0); else passed++;
  endtask

  task automatic test_stretch();
    slave_mode = 1;
    // bit 3 Q1 begins 16 + 3*16 + 4 = 68 edges after acceptance
    run_cmd(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 400, 68, NONE);
    checks++; if (g_lat != 223) $display("FAIL stretch_latency got=%0d want=223", g_lat); else passed++;
    checks++; if (g_tmr != 0) $display("FAIL stretch_timer_held got=%0d want=0", g_tmr); else passed++;
    checks++; if (cap_nack !== 1'b0) $display("FAIL stretch_nack got=%b want=0", cap_nack); else passed++;
    slave_mode = 0;
  endtask

  task automatic test_back_to_back();
    int st0;
    slave_mode = 1;
    run_cmd(1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 400, NONE, NONE);
    checks++; if (g_lat != 161) $display("FAIL b2b_wr_latency got=%0d want=161", g_lat); else passed++;
    checks++; if (oen_scl !== 1'b1) $display("FAIL b2b_scl_held got=%b want=1", oen_scl); else passed++;
    slave_mode = 2;
    rbyte = 8'h96;
    st0 = start_cnt;
    run_cmd(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 400, NONE, NONE);
    checks++; if (g_lat != 173) $display("FAIL b2b_rd_latency got=%0d want=173", g_lat); else passed++;
    checks++; if (cap_rdata !== 8'h96) $display("FAIL b2b_rd_data got=%h want=96", cap_rdata); else passed++;
    checks++; if (tr_sda[150] !== 1'b1) $display("FAIL b2b_master_ack got=%b want=1", tr_sda[150]); else passed++;
    checks++; if (start_cnt - st0 != 1) $display("FAIL b2b_repeated_start got=%0d want=1", start_cnt - st0); else passed++;
    slave_mode = 0;
  endtask

  task automatic test_arbitration();
    arb_mode = 1'b1;
    // bit 2 Q2 sample happens on edge 16 + 2*16 + 12 = 60
    run_cmd(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 400, NONE, NONE);
    checks++; if ({tr_scl[60], tr_sda[60]} !== 2'b00) $display("FAIL arb_oen_released got=%b want=00", {tr_scl[60], tr_sda[60]}); else passed++;
    checks++; if (g_lat != 61) $display("FAIL arb_latency got=%0d want=61", g_lat); else passed++;
    checks++; if (cap_arb !== 1'b1) $display("FAIL arb_lost_flag got=%b want=1", cap_arb); else passed++;
    arb_mode  = 1'b0;
    other_low = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int sp0;
    sp0 = stop_cnt;
    // bit 5 occupies edges 96..111; reset is sampled on edge 99
    run_cmd(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 300, NONE, 98);
    checks++; if (tr_scl[98] !== 1'b1) $display("FAIL rstmid_scl_before got=%b want=1", tr_scl[98]); else passed++;
    checks++; if ({tr_scl[99], tr_sda[99]} !== 2'b00) $display("FAIL rstmid_oen got=%b want=00", {tr_scl[99], tr_sda[99]}); else passed++;
    checks++; if ({tr_rdy[99], tr_rdy[100]} !== 2'b01) $display("FAIL rstmid_ready got=%b want=01", {tr_rdy[99], tr_rdy[100]}); else passed++;
    checks++; if (g_seen !== 1'b0) $display("FAIL rstmid_no_rsp got=%b want=0", g_seen); else passed++;
    checks++; if (stop_cnt != sp0) $display("FAIL rstmid_no_stop got=%0d want=0", stop_cnt - sp0); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_start_stop();
    test_read_nack();
    test_write_noack();
    test_stretch();
    test_back_to_back();
    test_arbitration();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/green_i2c_master.md
GREEN_I2C_MASTER -- requirements
Module: green_i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 250, gives the Clk_100 cycles per I2C quarter-bit (250 gives 100 kHz SCL); legal range is 2..4095.
REQ-002 Port Clk_100, input, 1 bit: the only clock; every flop samples on its rising edge.
REQ-003 Port SoftReset, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port cmd_valid, input, 1 bit: a command is offered.
REQ-005 Port cmd_ready, output, 1 bit: the block accepts a command; a command transfers when cmd_valid and cmd_ready are both high.
REQ-006 Port cmd_start, input, 1 bit: issue a START or repeated START before the byte.
REQ-007 Port cmd_stop, input, 1 bit: issue a STOP after the ACK bit.
REQ-008 Port cmd_read, input, 1 bit: 1 means read a byte, 0 means write cmd_wdata.
REQ-009 Port cmd_wdata, input, 8 bits: write byte, sent MSB first.
REQ-010 Port cmd_nack, input, 1 bit: on a read, 1 means the master NACKs the byte.
REQ-011 Port rsp_valid, output, 1 bit: one-cycle pulse marking command completion.
REQ-012 Port rsp_rdata, output, 8 bits: received byte; all zeros for writes.
REQ-013 Port rsp_nack, output, 1 bit: on a write, the slave did not ACK.
REQ-014 Port rsp_arb_lost, output, 1 bit: arbitration was lost during the command.
REQ-015 Ports b2g_I2C0_scl and b2g_I2C0_sda, inputs, 1 bit each: pad readback.
REQ-016 Ports g2b_I2C0_scl and g2b_I2C0_sda, outputs, 1 bit each: pad data, held constant 0.
REQ-017 Ports oen_I2C0_scl and oen_I2C0_sda, outputs, 1 bit each: 1 drives the line low, 0 releases it (open drain).

Function
REQ-018 The block SHALL pass b2g_I2C0_scl and b2g_I2C0_sda through a 2-flop synchronizer; all sampling uses the synchronized values.
REQ-019 A quarter timer SHALL count CLK_DIV cycles per phase, restart at every phase entry, and stay at 0 while waiting for SCL to go high.
REQ-020 The state machine SHALL have the states IDLE, START, BIT, ACK, STOP and RESP.
REQ-021 IDLE SHALL assert cmd_ready; cmd_ready SHALL deassert the cycle after a command is accepted, and the command fields SHALL be registered at acceptance.
REQ-022 On acceptance, the next state SHALL be START if cmd_start=1, otherwise BIT.
REQ-023 START SHALL run four quarters: S0 release SDA; S1 release SCL and wait for synchronized SCL=1; S2 drive SDA low; S3 drive SCL low. The next state is BIT.
REQ-024 BIT SHALL run 8 bits, each of four quarters, MSB first:
- Q0: SCL low; set SDA (write: drive low when the bit is 0, release when 1; read: release).
- Q1: release SCL, then wait for SCL=1 (clock stretching, unbounded).
- Q2: SCL high; sample SDA on the last cycle of the quarter.
- Q3: drive SCL low.
REQ-025 ACK SHALL be one further 4-quarter bit.
- Write: SDA released; sampled SDA=1 sets rsp_nack.
- Read: SDA driven low unless cmd_nack=1.
REQ-026 After ACK the block SHALL go to STOP if cmd_stop=1, otherwise to RESP with SCL held low (oen_I2C0_scl=1) so the bus stays owned.
REQ-027 STOP SHALL run three quarters: P0 drive SDA low; P1 release SCL and wait for SCL=1; P2 release SDA. The next state is RESP.
REQ-028 RESP SHALL assert rsp_valid for exactly one cycle with rsp_rdata, rsp_nack and rsp_arb_lost stable in that cycle, then return to IDLE.
REQ-029 Arbitration loss SHALL be detected when, during a write data bit, SDA is released but sampled 0 in Q2.
- Both oen outputs are cleared the next cycle.
- The remaining bits, ACK and STOP are skipped; the block goes to RESP with rsp_arb_lost=1.
REQ-030 The block SHALL not check that cmd_valid is held; it registers the command only in the acceptance cycle.
REQ-031 Without clock stretching, latency from acceptance to rsp_valid SHALL be (4·start + 36 + 3·stop)·CLK_DIV + 1 cycles, where start and stop are the command's cmd_start and cmd_stop flags (0 or 1).

Reset
REQ-032 While SoftReset=1, the block SHALL hold: state IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_arb_lost=0, oen_I2C0_scl=0, oen_I2C0_sda=0, timer=0 and synchronizers=1.
REQ-033 SoftReset asserted mid-transfer SHALL release both lines on the next edge; no STOP is generated and no rsp_valid is produced.
REQ-034 cmd_ready SHALL rise on the first cycle after SoftReset deasserts.

Verification
REQ-035 Write with START and STOP: CLK_DIV=4, write 0xA5, slave ACKs -> SDA pattern 1,0,1,0,0,1,0,1 sampled at the SCL rising edges; rsp_valid 173 cycles after acceptance with rsp_nack=0.
REQ-036 Read with NACK: CLK_DIV=4, no START, cmd_stop=1, cmd_nack=1, slave drives 0x3C -> rsp_rdata=0x3C; oen_I2C0_sda=0 during ACK; rsp_valid 157 cycles after acceptance.
REQ-037 Write with no ACK: the slave leaves SDA released during ACK -> rsp_nack=1; STOP is still issued.
REQ-038 Clock stretching: the slave holds SCL low for 50 cycles in bit 3 Q1 -> the timer stays at 0 and total latency grows by exactly 50 cycles.
REQ-039 Arbitration loss: write 0xFF while another master pulls SDA low in bit 2 -> both oen outputs are 0 one cycle after the Q2 sample, and rsp_arb_lost=1.
REQ-040 Reset during bit 5: assert SoftReset for 1 cycle -> both oen outputs are 0 and rsp_valid stays 0; cmd_ready=1 on the next cycle.
